// File: rtl/flash_cmd_sequencer_if.sv
// Command and flash-pin bundle for flash_cmd_sequencer.
// The master side is the mapper/board; the slave side is the sequencer.
interface flash_cmd_sequencer_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [26:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [26:0] fl_addr;
    logic [7:0]  fl_dout;
    logic [7:0]  fl_din;
    logic        fl_drive;
    logic        fl_ce_n;
    logic        fl_oe_n;
    logic        fl_we_n;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, fl_din,
        input  busy, done, error, fl_addr, fl_dout, fl_drive,
               fl_ce_n, fl_oe_n, fl_we_n
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, fl_din,
        output busy, done, error, fl_addr, fl_dout, fl_drive,
               fl_ce_n, fl_oe_n, fl_we_n
    );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// JEDEC command sequencer for the PRG flash: unlock/program/erase write cycles
// followed by DQ6-toggle / DQ5-fault completion polling.
module flash_cmd_sequencer #(
    parameter logic [26:0] UNLOCK_ADDR1 = 27'h0000AAA,
    parameter logic [26:0] UNLOCK_ADDR2 = 27'h0000555,
    parameter int unsigned TIMEOUT_BITS = 22
) (
    input  logic                  m2,
    input  logic                  reset,
    flash_cmd_sequencer_if.slave  bus
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_W_SETUP = 4'd1;
    localparam logic [3:0] S_W_PULSE = 4'd2;
    localparam logic [3:0] S_W_HOLD  = 4'd3;
    localparam logic [3:0] S_P_RD1   = 4'd4;
    localparam logic [3:0] S_P_RD2   = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_FAIL    = 4'd8;

    localparam logic [1:0] OP_PROGRAM = 2'd0;
    localparam logic [1:0] OP_SECTOR  = 2'd1;
    localparam logic [1:0] OP_CHIP    = 2'd2;
    localparam logic [1:0] OP_RESET   = 2'd3;

    localparam logic [TIMEOUT_BITS-1:0] TO_ONE = 1;

    typedef struct packed {
        logic [26:0] addr;
        logic [7:0]  data;
    } wr_t;

    // One entry of the bus-write list for a given operation and index.
    function automatic wr_t wr_entry(input logic [1:0]  op,
                                     input logic [2:0]  idx,
                                     input logic [26:0] addr,
                                     input logic [7:0]  data);
        wr_t e;
        e.addr = UNLOCK_ADDR1;
        e.data = 8'hAA;
        if (op == OP_RESET) begin
            e.addr = addr;
            e.data = 8'hF0;
        end else begin
            case (idx)
                3'd0: begin e.addr = UNLOCK_ADDR1; e.data = 8'hAA; end
                3'd1: begin e.addr = UNLOCK_ADDR2; e.data = 8'h55; end
                3'd2: begin
                    e.addr = UNLOCK_ADDR1;
                    e.data = (op == OP_PROGRAM) ? 8'hA0 : 8'h80;
                end
                3'd3: begin
                    e.addr = (op == OP_PROGRAM) ? addr : UNLOCK_ADDR1;
                    e.data = (op == OP_PROGRAM) ? data : 8'hAA;
                end
                3'd4: begin e.addr = UNLOCK_ADDR2; e.data = 8'h55; end
                default: begin
                    e.addr = (op == OP_SECTOR) ? addr : UNLOCK_ADDR1;
                    e.data = (op == OP_SECTOR) ? 8'h30 : 8'h10;
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [2:0] last_idx(input logic [1:0] op);
        case (op)
            OP_RESET:   return 3'd0;
            OP_PROGRAM: return 3'd3;
            default:    return 3'd5;
        endcase
    endfunction

    logic [3:0]              state_q,   state_d;
    logic [2:0]              widx_q,    widx_d;
    logic [1:0]              op_q,      op_d;
    logic [26:0]             caddr_q,   caddr_d;
    logic [7:0]              cdata_q,   cdata_d;
    logic                    a_dq6_q,   a_dq6_d;
    logic [7:0]              rd_b_q,    rd_b_d;
    logic [TIMEOUT_BITS-1:0] to_q,      to_d;
    logic                    done_q,    done_d;
    logic                    error_q,   error_d;
    logic                    busy_q,    busy_d;
    logic [26:0]             fl_addr_q, fl_addr_d;
    logic [7:0]              fl_dout_q, fl_dout_d;
    logic                    drive_q,   drive_d;
    logic                    ce_n_q,    ce_n_d;
    logic                    oe_n_q,    oe_n_d;
    logic                    we_n_q,    we_n_d;

    wr_t        nxt_wr;
    logic [7:0] exp_byte;
    logic       to_expired;

    assign exp_byte   = (op_q == OP_PROGRAM) ? cdata_q : 8'hFF;
    assign to_expired = &to_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        widx_d    = widx_q;
        op_d      = op_q;
        caddr_d   = caddr_q;
        cdata_d   = cdata_q;
        a_dq6_d   = a_dq6_q;
        rd_b_d    = rd_b_q;
        to_d      = to_q;
        done_d    = done_q;
        error_d   = error_q;
        fl_addr_d = fl_addr_q;
        fl_dout_d = fl_dout_q;
        nxt_wr    = wr_entry(op_q, widx_q + 3'd1, caddr_q, cdata_q);

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    nxt_wr    = wr_entry(bus.cmd_op, 3'd0, bus.cmd_addr, bus.cmd_data);
                    op_d      = bus.cmd_op;
                    caddr_d   = bus.cmd_addr;
                    cdata_d   = bus.cmd_data;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    widx_d    = 3'd0;
                    fl_addr_d = nxt_wr.addr;
                    fl_dout_d = nxt_wr.data;
                    state_d   = S_W_SETUP;
                end
            end
            S_W_SETUP: state_d = S_W_PULSE;
            S_W_PULSE: state_d = S_W_HOLD;
            S_W_HOLD: begin
                if (widx_q == last_idx(op_q)) begin
                    if (op_q == OP_RESET) begin
                        state_d = S_DONE;
                    end else begin
                        to_d      = '0;
                        fl_addr_d = caddr_q;
                        state_d   = S_P_RD1;
                    end
                end else begin
                    widx_d    = widx_q + 3'd1;
                    fl_addr_d = nxt_wr.addr;
                    fl_dout_d = nxt_wr.data;
                    state_d   = S_W_SETUP;
                end
            end
            S_P_RD1: begin
                a_dq6_d = bus.fl_din[6];
                to_d    = to_q + TO_ONE;
                state_d = to_expired ? S_FAIL : S_P_RD2;
            end
            S_P_RD2: begin
                rd_b_d  = bus.fl_din;
                to_d    = to_q + TO_ONE;
                state_d = to_expired ? S_FAIL : S_CHECK;
            end
            S_CHECK: begin
                to_d = to_q + TO_ONE;
                // Timeout outranks whatever the toggle bits say.
                if (to_expired)                 state_d = S_FAIL;
                else if (a_dq6_q == rd_b_q[6])  state_d = (rd_b_q == exp_byte) ? S_DONE : S_FAIL;
                else if (rd_b_q[5])             state_d = S_FAIL;
                else                            state_d = S_P_RD1;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_FAIL: begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pins are registered from the next state so they match state_q without glitches.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        drive_d = 1'b0;
        case (state_d)
            S_W_SETUP: begin ce_n_d = 1'b0; drive_d = 1'b1; end
            S_W_PULSE: begin ce_n_d = 1'b0; we_n_d = 1'b0; drive_d = 1'b1; end
            S_W_HOLD:  drive_d = 1'b1;
            S_P_RD1, S_P_RD2: begin ce_n_d = 1'b0; oe_n_d = 1'b0; end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            widx_q    <= '0;
            op_q      <= '0;
            caddr_q   <= '0;
            cdata_q   <= '0;
            a_dq6_q   <= 1'b0;
            rd_b_q    <= '0;
            to_q      <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            fl_addr_q <= '0;
            fl_dout_q <= '0;
            drive_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            op_q      <= op_d;
            caddr_q   <= caddr_d;
            cdata_q   <= cdata_d;
            a_dq6_q   <= a_dq6_d;
            rd_b_q    <= rd_b_d;
            to_q      <= to_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            fl_addr_q <= fl_addr_d;
            fl_dout_q <= fl_dout_d;
            drive_q   <= drive_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.fl_addr  = fl_addr_q;
    assign bus.fl_dout  = fl_dout_q;
    assign bus.fl_drive = drive_q;
    assign bus.fl_ce_n  = ce_n_q;
    assign bus.fl_oe_n  = oe_n_q;
    assign bus.fl_we_n  = we_n_q;

endmodule

// File: doc/flash_cmd_sequencer.md
# flash_cmd_sequencer

Sequences JEDEC-style command cycles (unlock, byte program, sector erase, chip erase) onto the cartridge PRG flash and polls completion with the DQ6 toggle / DQ5 fault bits. It sits between the mapper register file and the flash control pins (`flash_ce`, `flash_oe`, `flash_we`, address/data). While `busy` is high it owns the flash bus; the top level multiplexes its outputs over the normal CPU-mapped path. This moves self-programming (save slots, menu updates) out of timing-critical 6502 code.

## Interface
- `UNLOCK_ADDR1`, default 27'h0000AAA: first unlock address (x8 mode).
- `UNLOCK_ADDR2`, default 27'h0000555: second unlock address.
- `TIMEOUT_BITS`, default 22: width of the poll-timeout counter, counted in clock cycles.
- `m2`  input  1  clock, CPU M2; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `cmd_valid`  input  1  one-cycle start strobe; accepted only when `busy`=0.
- `cmd_op`  input  2  0=program, 1=sector erase, 2=chip erase, 3=reset-to-read (single F0 write).
- `cmd_addr`  input  27  target byte address (program) or any address in the sector (sector erase).
- `cmd_data`  input  8  byte to program.
- `busy`  output  1  sequencer owns flash bus.
- `done`  output  1  sticky: last command completed successfully.
- `error`  output  1  sticky: last command failed (DQ5 fault, verify mismatch or timeout).
- `fl_addr`  output  27  flash address.
- `fl_dout`  output  8  write data to flash.
- `fl_din`  input  8  read data from flash.
- `fl_drive`  output  1  1 = top level drives `fl_dout` onto the flash data bus.
- `fl_ce_n`, `fl_oe_n`, `fl_we_n`  output  1 each  active-low flash strobes.

## Operation
- Reset values: `busy`=0, `done`=0, `error`=0, `fl_addr`=0, `fl_dout`=0, `fl_drive`=0, all strobes 1. Reset mid-command aborts immediately; no partial cycle is completed. Software issues op 3 afterwards.
- Accepting `cmd_valid` latches op, addr and data, clears `done`/`error`, and sets `busy`. `cmd_valid` while `busy`=1 is ignored with no state change.
- Write lists, as (addr, data):
  - program: (U1,AA),(U2,55),(U1,A0),(cmd_addr,cmd_data).
  - sector erase: (U1,AA),(U2,55),(U1,80),(U1,AA),(U2,55),(cmd_addr,30).
  - chip erase: same as sector erase, with the last write (U1,10).
  - reset-to-read: (cmd_addr,F0), then go straight to DONE with no polling.
- A write-index counter (3 bits) steps through the list.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, P_RD1, P_RD2, CHECK, DONE_S, FAIL_S.
- IDLE -> W_SETUP on accepted command.
- W_SETUP: `fl_ce_n`=0, `fl_drive`=1, addr/data valid, `fl_we_n`=1.
- W_PULSE: `fl_we_n`=0.
- W_HOLD: `fl_we_n`=1 and `fl_ce_n`=1, while addr/data and `fl_drive` stay held. Then W_SETUP for the next entry, or P_RD1 after the last entry.
- P_RD1 / P_RD2:
  - Each state is 1 cycle with `fl_ce_n`=`fl_oe_n`=0, `fl_drive`=0 and `fl_addr`=cmd_addr.
  - `fl_din` is sampled at the end of P_RD1 (value A) and at the end of P_RD2 (value B).
- CHECK (strobes high), with expected byte E = cmd_data for program and FF for erase:
  - A[6]==B[6] and B==E -> DONE_S.
  - A[6]==B[6] and B!=E -> FAIL_S.
  - A[6]!=B[6] and B[5]==1 -> FAIL_S.
  - Otherwise -> P_RD1.
- Timeout counter: cleared on entering P_RD1 from W_HOLD and incremented every poll-phase cycle. When it reaches all-ones -> FAIL_S, with priority over the toggle result.
- DONE_S: `done`=1. FAIL_S: `error`=1. Both return to IDLE next cycle with `busy`=0.

## Timing
- Each bus write takes 3 cycles, so program is 12 cycles before the first poll and erase is 18.
- Each poll iteration takes 3 cycles (P_RD1, P_RD2, CHECK).
- `busy` rises on the cycle after `cmd_valid` is sampled and falls on the cycle after DONE_S or FAIL_S. `done`/`error` become visible in the same cycle that `busy` falls.
- Minimum program latency from accept to `busy`=0 is 12+3+1 = 16 cycles.
- `fl_oe_n` and `fl_we_n` are never 0 in the same cycle.
- `fl_drive` is 0 whenever `fl_oe_n`=0.
- There is no back-to-back acceptance: a new `cmd_valid` is honored at the earliest on the cycle `busy` is 0.

## Test plan
- Program 0x3C to 0x0123456 with a flash model that toggles DQ6 for 5 polls -> write sequence (AAA,AA),(555,55),(AAA,A0),(0123456,3C); `done`=1, `error`=0; `busy` high for 12+3·6+1 cycles.
- Sector erase at 0x0420000, model reads FF after 3 toggles -> six writes ending (0420000,30); `done`=1.
- Program where the model stops toggling but returns 0x3D -> `error`=1, `done`=0.
- Model toggles DQ6 with DQ5=1 -> FAIL_S on the first CHECK; `error`=1.
- Model toggles forever with TIMEOUT_BITS=6 -> `error`=1 once the counter saturates; strobes end high.
- Assert `reset` during W_PULSE of the third write -> all strobes 1, `fl_drive`=0, `busy`=0 in the same cycle. A second `cmd_valid` during busy is ignored (write count unchanged).
